// File: rtl/thumb_hw_aligner_if.sv
// Halfword fetch / aligned-instruction bus between instruction memory, the aligner and IF.
// The aligner sits on the slave side; the fetch environment drives the master side.
interface thumb_hw_aligner_if #(
    parameter int unsigned PC_W = 32
);
    logic [15:0]     hw_in;
    logic            hw_valid;
    logic            hw_ready;
    logic [31:0]     inst_out;
    logic            inst_is32;
    logic [PC_W-1:0] inst_pc;
    logic            inst_valid;
    logic            inst_ready;
    logic            flush;
    logic [PC_W-1:0] flush_pc;

    modport master (
        output hw_in, hw_valid, inst_ready, flush, flush_pc,
        input  hw_ready, inst_out, inst_is32, inst_pc, inst_valid
    );

    modport slave (
        input  hw_in, hw_valid, inst_ready, flush, flush_pc,
        output hw_ready, inst_out, inst_is32, inst_pc, inst_valid
    );
endinterface

// File: rtl/thumb_hw_aligner.sv
// Halfword prefetch FIFO that presents whole 16- or 32-bit Thumb-2 instructions to IF,
// tracking the byte PC of the head instruction and honouring flush/redirect.
module thumb_hw_aligner #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PC_W  = 32
) (
    input logic            clk,
    input logic            rst_n,
    thumb_hw_aligner_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    logic [15:0]     mem_q [DEPTH];
    ptr_t            rd_ptr_q, rd_ptr_d;
    ptr_t            wr_ptr_q, wr_ptr_d;
    cnt_t            count_q, count_d;
    logic [PC_W-1:0] pc_q, pc_d;

    logic [15:0] hw0, hw1;
    logic        head_is32;
    logic        valid;
    logic        push, pop;
    logic        unused_flush_pc_bit0;

    assign unused_flush_pc_bit0 = bus.flush_pc[0];

    // Pointers are exactly log2(DEPTH) wide, so +1 wraps mod DEPTH for free.
    assign hw0 = mem_q[rd_ptr_q];
    assign hw1 = mem_q[rd_ptr_q + ptr_t'(1)];

    // First halfword of a 32-bit encoding: hw0[15:11] in {11101, 11110, 11111}.
    assign head_is32 = (hw0[15:13] == 3'b111) && (hw0[12:11] != 2'b00);

    assign valid = head_is32 ? (count_q >= cnt_t'(2)) : (count_q != '0);

    assign bus.hw_ready   = (count_q < cnt_t'(DEPTH));
    assign bus.inst_valid = valid;
    assign bus.inst_is32  = valid & head_is32;
    assign bus.inst_pc    = valid ? pc_q : '0;

    always_comb begin
        bus.inst_out = '0;
        if (valid) begin
            bus.inst_out = head_is32 ? {hw0, hw1} : {hw0, 16'h0000};
        end
    end

    assign push = bus.hw_valid & bus.hw_ready;
    assign pop  = valid & bus.inst_ready;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        pc_d     = pc_q;
        if (bus.flush) begin
            // Redirect wins over any handshake in the same cycle.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            pc_d     = {bus.flush_pc[PC_W-1:1], 1'b0};
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + (head_is32 ? ptr_t'(2) : ptr_t'(1));
                pc_d     = pc_q + (head_is32 ? PC_W'(4) : PC_W'(2));
            end
            count_d = count_q + cnt_t'(push)
                    - (pop ? (head_is32 ? cnt_t'(2) : cnt_t'(1)) : cnt_t'(0));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            pc_q     <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            pc_q     <= pc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !bus.flush) begin
            mem_q[wr_ptr_q] <= bus.hw_in;
        end
    end
endmodule

// File: tb/tb_thumb_hw_aligner.sv
// Directed and randomized checks of thumb_hw_aligner against a halfword-queue reference model.
module tb_thumb_hw_aligner;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PC_W  = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    thumb_hw_aligner_if #(.PC_W(PC_W)) bus ();

    thumb_hw_aligner #(
        .DEPTH(DEPTH),
        .PC_W (PC_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int unsigned pass_cnt = 0;
    int unsigned chk_cnt  = 0;

    // Reference model: buffered halfwords in arrival order plus PC of the front one.
    logic [15:0] mq[$];
    logic [31:0] mpc;

    function automatic bit is32_hw(input logic [15:0] h);
        return (h[15:11] == 5'b11101) || (h[15:11] == 5'b11110) || (h[15:11] == 5'b11111);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic hv, input logic [15:0] h, input logic ir,
                         input logic fl, input logic [31:0] fpc);
        bus.hw_valid   = hv;
        bus.hw_in      = h;
        bus.inst_ready = ir;
        bus.flush      = fl;
        bus.flush_pc   = fpc;
    endtask

    task automatic model_exp(output logic v, output logic i32, output logic [31:0] o,
                             output logic [31:0] p);
        bit w;
        v = 1'b0; i32 = 1'b0; o = '0; p = '0;
        if (mq.size() > 0) begin
            w = is32_hw(mq[0]);
            if (mq.size() >= (w ? 2 : 1)) begin
                v   = 1'b1;
                i32 = w;
                o   = w ? {mq[0], mq[1]} : {mq[0], 16'h0000};
                p   = mpc;
            end
        end
    endtask

    task automatic expect_inst(input string tag, input logic v, input logic [31:0] o,
                               input logic i32, input logic [31:0] p);
        check({tag, "_valid"}, {31'd0, bus.inst_valid}, {31'd0, v});
        check({tag, "_out"}, bus.inst_out, o);
        check({tag, "_is32"}, {31'd0, bus.inst_is32}, {31'd0, i32});
        check({tag, "_pc"}, bus.inst_pc, p);
    endtask

    // Compare all outputs with the model, then advance one clock and update the model.
    task automatic cycle();
        logic        v, i32, hv, ir, fl;
        logic [31:0] o, p, fpc;
        logic [15:0] h;
        bit          do_push, do_pop;
        model_exp(v, i32, o, p);
        check("m_hw_ready", {31'd0, bus.hw_ready}, {31'd0, mq.size() < DEPTH});
        expect_inst("m", v, o, i32, p);
        hv = bus.hw_valid; h = bus.hw_in; ir = bus.inst_ready; fl = bus.flush; fpc = bus.flush_pc;
        do_push = hv && (mq.size() < DEPTH);
        do_pop  = v && ir;
        @(posedge clk);
        #1;
        if (fl) begin
            mq.delete();
            mpc = {fpc[31:1], 1'b0};
        end else begin
            if (do_pop) begin
                void'(mq.pop_front());
                if (i32) void'(mq.pop_front());
                mpc = mpc + (i32 ? 32'd4 : 32'd2);
            end
            if (do_push) mq.push_back(h);
        end
    endtask

    initial begin
        int unsigned pushed;
        int unsigned cycles;
        logic [15:0] hw;

        mpc   = '0;
        rst_n = 1'b0;
        drive(1'b1, 16'hBF08, 1'b0, 1'b0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hw_ready", {31'd0, bus.hw_ready}, 32'd1);
        expect_inst("rst", 1'b0, 32'd0, 1'b0, 32'd0);

        drive(1'b0, 16'h0000, 1'b0, 1'b0, 32'd0);
        rst_n = 1'b1;
        cycle();
        check("rst_idle_valid", {31'd0, bus.inst_valid}, 32'd0);

        // 16-bit stream
        drive(1'b1, 16'hBF08, 1'b0, 1'b0, 32'd0);
        cycle();
        expect_inst("s16a", 1'b1, 32'hBF08_0000, 1'b0, 32'd0);
        drive(1'b1, 16'h2001, 1'b1, 1'b0, 32'd0);
        cycle();
        expect_inst("s16b", 1'b1, 32'h2001_0000, 1'b0, 32'd2);
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 32'd0);
        cycle();
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 32'd0);
        cycle();

        // 32-bit instruction split by a stall
        drive(1'b1, 16'hF04F, 1'b1, 1'b0, 32'd0);
        cycle();
        check("s32_wait0", {31'd0, bus.inst_valid}, 32'd0);
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("s32_stall", {31'd0, bus.inst_valid}, 32'd0);
        end
        drive(1'b1, 16'h0105, 1'b0, 1'b0, 32'd0);
        cycle();
        expect_inst("s32", 1'b1, 32'hF04F_0105, 1'b1, 32'd0);
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 32'd0);
        cycle();
        drive(1'b1, 16'hBF00, 1'b0, 1'b0, 32'd0);
        cycle();
        expect_inst("s32_next", 1'b1, 32'hBF00_0000, 1'b0, 32'd4);

        // Backpressure and full, then in-order drain with pointer wrap
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 32'h10);
        cycle();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0, 32'd0);
            check("full_ready", {31'd0, bus.hw_ready}, {31'd0, i < 4});
            cycle();
        end
        check("full_ready_end", {31'd0, bus.hw_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'h2000 + 16'(i), 1'b1, 1'b0, 32'd0);
            expect_inst("full_pop", 1'b1, {16'h1000 + 16'(i), 16'h0000}, 1'b0,
                        32'h10 + 32'(2 * i));
            cycle();
        end
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 32'd0);
        for (int j = 0; j < 3; j++) begin
            expect_inst("wrap_pop", 1'b1, {16'h2001 + 16'(j), 16'h0000}, 1'b0,
                        32'h18 + 32'(2 * j));
            cycle();
        end

        // Flush with entries buffered and push/pop offered
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h3000 + 16'(i), 1'b0, 1'b0, 32'd0);
            cycle();
        end
        drive(1'b1, 16'h7777, 1'b1, 1'b1, 32'h0000_0101);
        cycle();
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 32'd0);
        check("flush_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("flush_ready", {31'd0, bus.hw_ready}, 32'd1);
        drive(1'b1, 16'h4608, 1'b0, 1'b0, 32'd0);
        cycle();
        expect_inst("flush_pc", 1'b1, 32'h4608_0000, 1'b0, 32'h100);
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 32'd0);
        cycle();

        // Randomized traffic against the model
        pushed = 0;
        cycles = 0;
        while (pushed < 2000 && cycles < 20000) begin
            hw = 16'($urandom);
            case ($urandom_range(0, 5))
                0: hw[15:11] = 5'b11101;
                1: hw[15:11] = 5'b11110;
                2: hw[15:11] = 5'b11111;
                default: ;
            endcase
            drive($urandom_range(0, 3) != 0, hw, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 99) == 0, $urandom);
            if (bus.hw_valid && !bus.flush && mq.size() < DEPTH) pushed++;
            cycle();
            cycles++;
        end
        check("rand_done", {31'd0, pushed >= 2000}, 32'd1);
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 32'd0);
        repeat (4) cycle();

        // Asynchronous reset in the middle of a partial 32-bit instruction
        drive(1'b1, 16'hF000, 1'b0, 1'b0, 32'd0);
        cycle();
        drive(1'b1, 16'hBF08, 1'b0, 1'b0, 32'd0);
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        mpc = '0;
        check("mid_rst_ready", {31'd0, bus.hw_ready}, 32'd1);
        expect_inst("mid_rst", 1'b0, 32'd0, 1'b0, 32'd0);
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle();
        check("mid_rst_after", {31'd0, bus.inst_valid}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
